// File: rtl/pe_mult_pipe.sv
// Pipelined signed multiplier array: one int16 product or two int8 products per lane.
// Elastic valid/ready pipeline with per-stage valid bits; bubbles collapse under stall.
module pe_mult_pipe #(
    parameter int LANES  = 32,
    parameter int DATA_W = 16,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [LANES*DATA_W-1:0]   mult_neuron,
    input  logic [LANES*DATA_W-1:0]   mult_weight,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic [LANES*2*DATA_W-1:0] mult_result
);

    localparam int H  = DATA_W / 2;
    localparam int RW = 2 * DATA_W;
    localparam int PW = LANES * RW;

    logic [PW-1:0] w_prod;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic        [DATA_W-1:0] w_n;
        logic        [DATA_W-1:0] w_w;
        logic signed [RW-1:0]     w_n16;
        logic signed [RW-1:0]     w_w16;
        logic signed [RW-1:0]     w_p16;
        logic signed [DATA_W-1:0] w_nh;
        logic signed [DATA_W-1:0] w_nl;
        logic signed [DATA_W-1:0] w_wh;
        logic signed [DATA_W-1:0] w_wl;
        logic signed [DATA_W-1:0] w_ph;
        logic signed [DATA_W-1:0] w_pl;

        assign w_n = mult_neuron[i*DATA_W +: DATA_W];
        assign w_w = mult_weight[i*DATA_W +: DATA_W];

        // Operands pre-extended so each product is exact at its result width.
        assign w_n16 = {{DATA_W{w_n[DATA_W-1]}}, w_n};
        assign w_w16 = {{DATA_W{w_w[DATA_W-1]}}, w_w};
        assign w_nh  = {{H{w_n[DATA_W-1]}}, w_n[DATA_W-1:H]};
        assign w_wh  = {{H{w_w[DATA_W-1]}}, w_w[DATA_W-1:H]};
        assign w_nl  = {{H{w_n[H-1]}}, w_n[H-1:0]};
        assign w_wl  = {{H{w_w[H-1]}}, w_w[H-1:0]};

        assign w_p16 = w_n16 * w_w16;
        assign w_ph  = w_nh * w_wh;
        assign w_pl  = w_nl * w_wl;

        assign w_prod[i*RW +: RW] = in_mode ? {w_ph, w_pl} : w_p16;
    end

    logic [STAGES-1:0]         r_v;
    logic [STAGES-1:0]         r_mode;
    logic [STAGES-1:0][PW-1:0] r_data;

    logic [STAGES-1:0]         w_en;
    logic [STAGES-1:0]         w_up_v;
    logic [STAGES-1:0]         w_up_m;
    logic [STAGES-1:0][PW-1:0] w_up_d;

    // A stage can move iff some stage at or downstream of it is empty, or the output drains.
    for (genvar k = 0; k < STAGES; k++) begin : g_en
        assign w_en[k] = out_ready | ~(&r_v[STAGES-1:k]);
    end

    assign w_up_v[0] = in_valid;
    assign w_up_m[0] = in_mode;
    assign w_up_d[0] = w_prod;

    for (genvar k = 1; k < STAGES; k++) begin : g_up
        assign w_up_v[k] = r_v[k-1];
        assign w_up_m[k] = r_mode[k-1];
        assign w_up_d[k] = r_data[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_mode <= '0;
            r_data <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_en[k]) begin
                    r_v[k] <= w_up_v[k];
                    if (w_up_v[k]) begin
                        r_mode[k] <= w_up_m[k];
                        r_data[k] <= w_up_d[k];
                    end
                end
            end
        end
    end

    assign in_ready    = w_en[0];
    assign out_valid   = r_v[STAGES-1];
    assign out_mode    = r_mode[STAGES-1];
    assign mult_result = r_data[STAGES-1];

endmodule

// File: tb/tb_pe_mult_pipe.sv
// Bench for pe_mult_pipe: directed corners plus randomized streams
// checked against an arithmetic reference and an in-order queue.
module tb_pe_mult_pipe;

    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_mode;
    logic          out_valid, out_ready, out_mode;
    logic [511:0]  mult_neuron, mult_weight;
    logic [1023:0] mult_result;

    logic        s_iv [2];
    logic        s_ir [2];
    logic        s_im [2];
    logic        s_ov [2];
    logic        s_or [2];
    logic        s_om [2];
    logic [31:0] s_n  [2];
    logic [31:0] s_w  [2];
    logic [63:0] s_r  [2];

    int checks   = 0;
    int failures = 0;
    int nacc     = 0;
    int ndel     = 0;

    logic [1024:0] q [$];

    always #5 clk = ~clk;

    pe_mult_pipe #(.LANES(32), .DATA_W(16), .STAGES(ST)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .mult_neuron(mult_neuron), .mult_weight(mult_weight),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .mult_result(mult_result)
    );

    pe_mult_pipe #(.LANES(4), .DATA_W(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_iv[0]), .in_ready(s_ir[0]), .in_mode(s_im[0]),
        .mult_neuron(s_n[0]), .mult_weight(s_w[0]),
        .out_valid(s_ov[0]), .out_ready(s_or[0]), .out_mode(s_om[0]),
        .mult_result(s_r[0])
    );

    pe_mult_pipe #(.LANES(4), .DATA_W(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_iv[1]), .in_ready(s_ir[1]), .in_mode(s_im[1]),
        .mult_neuron(s_n[1]), .mult_weight(s_w[1]),
        .out_valid(s_ov[1]), .out_ready(s_or[1]), .out_mode(s_om[1]),
        .mult_result(s_r[1])
    );

    function automatic longint mask(int b);
        return (longint'(1) << b) - 1;
    endfunction

    function automatic longint sx(longint x, int b);
        longint v;
        v = x & mask(b);
        return (v >= (longint'(1) << (b - 1))) ? v - (longint'(1) << b) : v;
    endfunction

    function automatic longint ref_lane(int dw, longint n, longint w, logic m);
        longint ph, pl;
        int h;
        if (!m) return (sx(n, dw) * sx(w, dw)) & mask(2 * dw);
        h  = dw / 2;
        ph = sx(n >> h, h) * sx(w >> h, h);
        pl = sx(n, h) * sx(w, h);
        return ((ph & mask(dw)) << dw) | (pl & mask(dw));
    endfunction

    function automatic logic [1023:0] ref_vec(int lanes, int dw,
                                              logic [511:0] n, logic [511:0] w,
                                              logic m);
        logic [1023:0] r, t;
        logic [511:0]  a, b;
        r = '0;
        for (int i = 0; i < lanes; i++) begin
            a = n >> (i * dw);
            b = w >> (i * dw);
            t = '0;
            t[63:0] = ref_lane(dw, longint'(a[63:0]) & mask(dw),
                               longint'(b[63:0]) & mask(dw), m);
            r = r | (t << (i * 2 * dw));
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(string tag, logic [1023:0] obs, logic [1023:0] exp);
        int k;
        checks++;
        assert (obs === exp) else begin
            failures++;
            k = 0;
            for (int i = 31; i >= 0; i--)
                if (obs[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            $error("FAIL %s chunk=%0d observed=%h expected=%h",
                   tag, k, obs[k*32 +: 32], exp[k*32 +: 32]);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 16; i++) begin
            mult_neuron[i*32 +: 32] = $urandom;
            mult_weight[i*32 +: 32] = $urandom;
        end
    endtask

    // Bookkeeping for one cycle of the main DUT, then advance to just after the edge.
    task automatic step();
        #2;
        chk("in_ready", in_ready, (q.size() < ST) || out_ready);
        chk("spurious_valid", out_valid && (q.size() == 0), 0);
        if (out_valid && q.size() > 0) begin
            chk("out_mode", out_mode, q[0][1024]);
            chk_vec("result", mult_result, q[0][1023:0]);
            if (out_ready) begin
                void'(q.pop_front());
                ndel++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back({in_mode, ref_vec(32, 16, mult_neuron, mult_weight, in_mode)});
            nacc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drained", q.size(), 0);
    endtask

    task automatic sweep(int j, int stg);
        logic [64:0]   sq [$];
        logic [1023:0] e;
        logic          m;
        int            n;
        int            acc, del;
        acc = 0;
        del = 0;
        s_or[j] = 1'b1;
        s_iv[j] = 1'b1;
        s_im[j] = 1'($urandom);
        s_n[j]  = $urandom;
        s_w[j]  = $urandom;
        #2;
        chk($sformatf("s%0d_lat_ready", stg), s_ir[j], 1);
        e = ref_vec(4, 8, {480'b0, s_n[j]}, {480'b0, s_w[j]}, s_im[j]);
        m = s_im[j];
        @(posedge clk);
        #1;
        s_iv[j] = 1'b0;
        n = 0;
        while (!s_ov[j] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("s%0d_latency", stg), n, stg - 1);
        chk_vec($sformatf("s%0d_lat_data", stg), {960'b0, s_r[j]}, e);
        chk($sformatf("s%0d_lat_mode", stg), s_om[j], m);
        @(posedge clk);
        #1;
        for (int c = 0; c < 320; c++) begin
            if (c < 300) begin
                s_or[j] = ($urandom_range(0, 3) != 0);
                s_iv[j] = 1'($urandom);
                s_im[j] = 1'($urandom);
                s_n[j]  = $urandom;
                s_w[j]  = $urandom;
            end else begin
                s_or[j] = 1'b1;
                s_iv[j] = 1'b0;
            end
            #2;
            chk($sformatf("s%0d_in_ready", stg), s_ir[j], (sq.size() < stg) || s_or[j]);
            chk($sformatf("s%0d_spurious", stg), s_ov[j] && (sq.size() == 0), 0);
            if (s_ov[j] && sq.size() > 0) begin
                chk($sformatf("s%0d_mode", stg), s_om[j], sq[0][64]);
                chk_vec($sformatf("s%0d_result", stg), {960'b0, s_r[j]},
                        {960'b0, sq[0][63:0]});
                if (s_or[j]) begin
                    void'(sq.pop_front());
                    del++;
                end
            end
            if (s_iv[j] && s_ir[j]) begin
                e = ref_vec(4, 8, {480'b0, s_n[j]}, {480'b0, s_w[j]}, s_im[j]);
                sq.push_back({s_im[j], e[63:0]});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("s%0d_drained", stg), sq.size(), 0);
        chk($sformatf("s%0d_count", stg), del, acc);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n0, d0;
        for (int j = 0; j < 2; j++) begin
            s_iv[j] = 1'b0;
            s_im[j] = 1'b0;
            s_or[j] = 1'b1;
            s_n[j]  = '0;
            s_w[j]  = '0;
        end
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_mode     = 1'b0;
        out_ready   = 1'b1;
        mult_neuron = '0;
        mult_weight = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_mode", out_mode, 0);
        chk_vec("rst_result", mult_result, '0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // int16 corners
        mult_neuron[63:0] = 64'h0003_7FFF_8000_FFFF;
        mult_weight[63:0] = 64'hFFFE_8000_8000_FFFF;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        chk("c16_early_valid", out_valid, 0);
        step();
        #2;
        chk("c16_valid", out_valid, 1);
        chk("c16_lane0", mult_result[31:0], 32'h0000_0001);
        chk("c16_lane1", mult_result[63:32], 32'h4000_0000);
        chk("c16_lane2", mult_result[95:64], 32'hC000_8000);
        chk("c16_lane3", mult_result[127:96], 32'hFFFF_FFFA);
        step();

        // int8 split: -128*127 high, 127*127 low
        mult_neuron = '0;
        mult_weight = '0;
        mult_neuron[15:0] = 16'h807F;
        mult_weight[15:0] = 16'h7F7F;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        chk("i8_mode", out_mode, 1);
        chk("i8_lane0", mult_result[31:0], 32'hC080_3F01);
        step();

        // back-to-back mixed-mode stream
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            in_mode  = 1'($urandom);
            in_valid = 1'b1;
            #2;
            chk("stream_valid", out_valid, i >= 2);
            chk("stream_ready", in_ready, 1);
            step();
        end
        drain();

        // backpressure
        n0 = nacc;
        d0 = ndel;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            in_mode  = 1'($urandom);
            in_valid = 1'b1;
            step();
        end
        chk("bp_accepted", nacc - n0, ST);
        #2;
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_mode  = 1'($urandom);
            in_valid = 1'b1;
            step();
        end
        drain();
        chk("bp_count", ndel - d0, nacc - n0);

        // reset with two transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_ops();
            in_mode  = 1'($urandom);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk_vec("mid_rst_result", mult_result, '0);
        chk("mid_rst_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        rand_ops();
        in_mode  = 1'($urandom);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        chk("post_rst_early", out_valid, 0);
        step();
        #2;
        chk("post_rst_valid", out_valid, 1);
        step();
        chk("post_rst_empty", q.size(), 0);

        sweep(0, 1);
        sweep(1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
